// File: rtl/hazard_stall_controller_pkg.sv
// Shared pipeline definitions for the hazard/stall controller: state encoding,
// register index width, control bundle and the load-use detection helper.
package hazard_stall_controller_pkg;

  localparam int unsigned REG_IDX_W   = 5;
  localparam int unsigned FLUSH_CNT_W = 4;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_LU_STALL = 2'd1,
    ST_FLUSH    = 2'd2
  } state_e;

  typedef struct packed {
    logic pc_write;
    logic if_id_write;
    logic ctrl_bubble;
    logic if_id_flush;
    logic id_ex_flush;
  } ctrl_t;

  // Pipeline held with every stage cleared while reset is asserted
  localparam ctrl_t CTRL_RESET = '{pc_write: 1'b0, if_id_write: 1'b0, ctrl_bubble: 1'b1,
                                   if_id_flush: 1'b1, id_ex_flush: 1'b1};

  localparam ctrl_t CTRL_IDLE  = '{pc_write: 1'b1, if_id_write: 1'b1, ctrl_bubble: 1'b0,
                                   if_id_flush: 1'b0, id_ex_flush: 1'b0};

  // A load in EX feeding either source of the instruction in ID; x0 never hazards
  function automatic logic load_use_hit(input logic                 mem_read,
                                        input logic [REG_IDX_W-1:0] rd,
                                        input logic [REG_IDX_W-1:0] rs1,
                                        input logic [REG_IDX_W-1:0] rs2);
    return mem_read && (rd != '0) && ((rd == rs1) || (rd == rs2));
  endfunction

endpackage

// File: rtl/hazard_stall_controller_sat_counter.sv
// Saturating up-counter used for the stall and flush performance counters.
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/hazard_stall_controller.sv
// Load-use / branch-flush / imem-wait hazard controller with combinational
// pipeline control decode and saturating stall/flush performance counters.
module hazard_stall_controller
  import hazard_stall_controller_pkg::*;
#(
  parameter int unsigned FLUSH_DEPTH = 2,
  parameter int unsigned CNT_W       = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 ID_EX_MemRead,
  input  logic [REG_IDX_W-1:0] ID_EX_rd,
  input  logic [REG_IDX_W-1:0] IF_ID_rs1,
  input  logic [REG_IDX_W-1:0] IF_ID_rs2,
  input  logic                 branch_taken,
  input  logic                 imem_ready,
  output logic                 PCWrite,
  output logic                 IF_ID_Write,
  output logic                 ctrl_bubble,
  output logic                 IF_ID_Flush,
  output logic                 ID_EX_Flush,
  output logic [CNT_W-1:0]     stall_cycles,
  output logic [CNT_W-1:0]     flush_cycles
);

  state_e                 state;
  state_e                 state_next;
  logic [FLUSH_CNT_W-1:0] flush_cnt;
  logic [FLUSH_CNT_W-1:0] flush_cnt_next;
  ctrl_t                  ctrl;
  ctrl_t                  ctrl_out;
  logic                   lu_hit;
  logic                   stall_inc;
  logic                   flush_inc;

  assign lu_hit = load_use_hit(ID_EX_MemRead, ID_EX_rd, IF_ID_rs1, IF_ID_rs2);

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_RUN;
      flush_cnt <= '0;
    end else begin
      state     <= state_next;
      flush_cnt <= flush_cnt_next;
    end
  end

  // Next-state and control decode, priority: branch > flush > load-use > imem wait
  always_comb begin
    ctrl           = CTRL_IDLE;
    state_next     = state;
    flush_cnt_next = flush_cnt;

    if (branch_taken) begin
      ctrl.if_id_flush = 1'b1;
      ctrl.id_ex_flush = 1'b1;
      state_next       = ST_FLUSH;
      flush_cnt_next   = FLUSH_CNT_W'(FLUSH_DEPTH - 1);
    end else if (state == ST_FLUSH) begin
      ctrl.if_id_flush = 1'b1;
      ctrl.pc_write    = imem_ready;
      // Bubbles only retire on cycles where a fetch actually returned
      if (imem_ready) begin
        if (flush_cnt == '0) begin
          state_next = ST_RUN;
        end else begin
          flush_cnt_next = flush_cnt - FLUSH_CNT_W'(1);
        end
      end
    end else if (lu_hit && (state == ST_RUN)) begin
      ctrl.pc_write    = 1'b0;
      ctrl.if_id_write = 1'b0;
      ctrl.ctrl_bubble = 1'b1;
      state_next       = ST_LU_STALL;
    end else begin
      state_next = ST_RUN;
      if (!imem_ready) begin
        ctrl.pc_write    = 1'b0;
        ctrl.if_id_write = 1'b0;
        ctrl.ctrl_bubble = 1'b1;
      end
    end
  end

  assign ctrl_out    = reset ? ctrl : CTRL_RESET;
  assign PCWrite     = ctrl_out.pc_write;
  assign IF_ID_Write = ctrl_out.if_id_write;
  assign ctrl_bubble = ctrl_out.ctrl_bubble;
  assign IF_ID_Flush = ctrl_out.if_id_flush;
  assign ID_EX_Flush = ctrl_out.id_ex_flush;

  // Imem waits inside a flush are accounted as flush time, not stall time
  assign stall_inc = !ctrl.pc_write && (state != ST_FLUSH);
  assign flush_inc = ctrl.if_id_flush;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (reset),
    .inc   (stall_inc),
    .count (stall_cycles)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst_n (reset),
    .inc   (flush_inc),
    .count (flush_cycles)
  );

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Randomized and directed bench for hazard_stall_controller against an
// owed-bubble behavioural model, checked on every falling clock edge.
module tb_hazard_stall_controller;

  localparam int unsigned FD  = 2;
  localparam int unsigned CW  = 5;
  localparam int          SAT = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          mem_read = 1'b0;
  logic [4:0]    rd = '0;
  logic [4:0]    rs1 = '0;
  logic [4:0]    rs2 = '0;
  logic          br = 1'b0;
  logic          ready = 1'b1;
  logic          pc_w, ifid_w, bubble, ifid_f, idex_f;
  logic [CW-1:0] stall_cnt, flush_cnt;

  int checks = 0;
  int errors = 0;

  hazard_stall_controller #(.FLUSH_DEPTH(FD), .CNT_W(CW)) dut (
    .clk           (clk),
    .reset         (reset),
    .ID_EX_MemRead (mem_read),
    .ID_EX_rd      (rd),
    .IF_ID_rs1     (rs1),
    .IF_ID_rs2     (rs2),
    .branch_taken  (br),
    .imem_ready    (ready),
    .PCWrite       (pc_w),
    .IF_ID_Write   (ifid_w),
    .ctrl_bubble   (bubble),
    .IF_ID_Flush   (ifid_f),
    .ID_EX_Flush   (idex_f),
    .stall_cycles  (stall_cnt),
    .flush_cycles  (flush_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: number of imem-ready flush cycles still owed, and whether the
  // previous cycle started a load-use stall.
  int m_owed = 0;
  bit m_after_stall = 1'b0;
  int m_stall = 0;
  int m_flush = 0;
  bit e_pc, e_ifw, e_bub, e_iff, e_idf, m_lu, m_in_flush, m_next_after;

  always @(negedge clk) begin
    if (!reset) begin
      m_owed = 0; m_after_stall = 1'b0; m_stall = 0; m_flush = 0;
      e_pc = 1'b0; e_ifw = 1'b0; e_bub = 1'b1; e_iff = 1'b1; e_idf = 1'b1;
      m_in_flush = 1'b0;
    end else begin
      m_lu = mem_read && (rd != 0) && ((rd == rs1) || (rd == rs2));
      m_in_flush = (m_owed > 0);
      e_pc = 1'b1; e_ifw = 1'b1; e_bub = 1'b0; e_iff = 1'b0; e_idf = 1'b0;
      m_next_after = 1'b0;
      if (br) begin
        e_iff = 1'b1; e_idf = 1'b1;
        m_owed = FD;
      end else if (m_in_flush) begin
        e_iff = 1'b1; e_pc = ready;
        if (ready) m_owed--;
      end else if (m_lu && !m_after_stall) begin
        e_pc = 1'b0; e_ifw = 1'b0; e_bub = 1'b1;
        m_next_after = 1'b1;
      end else if (!ready) begin
        e_pc = 1'b0; e_ifw = 1'b0; e_bub = 1'b1;
      end
    end
    chk("PCWrite", int'(pc_w), int'(e_pc));
    chk("IF_ID_Write", int'(ifid_w), int'(e_ifw));
    chk("ctrl_bubble", int'(bubble), int'(e_bub));
    chk("IF_ID_Flush", int'(ifid_f), int'(e_iff));
    chk("ID_EX_Flush", int'(idex_f), int'(e_idf));
    chk("stall_cycles", int'(stall_cnt), m_stall);
    chk("flush_cycles", int'(flush_cnt), m_flush);
    if (reset) begin
      if (!e_pc && !m_in_flush && m_stall < SAT) m_stall++;
      if (e_iff && m_flush < SAT) m_flush++;
      m_after_stall = m_next_after;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    mem_read = 1'b0; rd = '0; rs1 = '0; rs2 = '0; br = 1'b0; ready = 1'b1;
  endtask

  task automatic reset_dut();
    step();
    reset = 1'b0;
    idle();
    step();
    step();
    reset = 1'b1;
  endtask

  int fc, ec, pz;

  initial begin
    // Reset values while asserted
    #2;
    chk("rst_PCWrite", int'(pc_w), 0);
    chk("rst_IF_ID_Write", int'(ifid_w), 0);
    chk("rst_ctrl_bubble", int'(bubble), 1);
    chk("rst_IF_ID_Flush", int'(ifid_f), 1);
    chk("rst_ID_EX_Flush", int'(idex_f), 1);
    chk("rst_stall_cycles", int'(stall_cnt), 0);
    chk("rst_flush_cycles", int'(flush_cnt), 0);
    reset_dut();

    // Load-use single-cycle stall
    mem_read = 1'b1; rd = 5'd5; rs1 = 5'd5; rs2 = 5'd0;
    #2;
    chk("lu_PCWrite", int'(pc_w), 0);
    chk("lu_bubble", int'(bubble), 1);
    step(); idle(); #2;
    chk("lu_PCWrite_next", int'(pc_w), 1);
    chk("lu_stall_cycles", int'(stall_cnt), 1);

    // rd = x0 never stalls
    reset_dut();
    mem_read = 1'b1; rd = 5'd0; rs1 = 5'd3; rs2 = 5'd0;
    #2;
    chk("x0_PCWrite", int'(pc_w), 1);
    step(); idle(); #2;
    chk("x0_stall_cycles", int'(stall_cnt), 0);

    // Branch flush length
    reset_dut();
    fc = 0; ec = 0;
    br = 1'b1; #2;
    fc += int'(ifid_f); ec += int'(idex_f);
    step(); br = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #2; fc += int'(ifid_f); ec += int'(idex_f);
      step();
    end
    chk("br_if_id_flush_len", fc, 3);
    chk("br_id_ex_flush_len", ec, 1);
    chk("br_flush_cycles", int'(flush_cnt), 3);

    // Branch beats simultaneous load-use
    reset_dut();
    mem_read = 1'b1; rd = 5'd7; rs2 = 5'd7; br = 1'b1;
    #2;
    chk("sim_PCWrite", int'(pc_w), 1);
    chk("sim_IF_ID_Flush", int'(ifid_f), 1);
    chk("sim_ID_EX_Flush", int'(idex_f), 1);
    chk("sim_bubble", int'(bubble), 0);
    step(); idle(); #2;
    chk("sim_stall_cycles", int'(stall_cnt), 0);

    // Imem wait inside a flush extends it
    reset_dut();
    fc = 0; pz = 0;
    br = 1'b1; #2;
    fc += int'(ifid_f);
    step(); br = 1'b0;
    for (int i = 0; i < 6; i++) begin
      ready = (i == 1 || i == 2) ? 1'b0 : 1'b1;
      #2;
      fc += int'(ifid_f);
      pz += int'(ifid_f && !pc_w);
      step();
    end
    ready = 1'b1;
    chk("wait_flush_len", fc, 5);
    chk("wait_pc_held", pz, 2);
    chk("wait_flush_cycles", int'(flush_cnt), 5);
    chk("wait_stall_cycles", int'(stall_cnt), 0);

    // Reset mid-flush
    reset_dut();
    br = 1'b1; step(); br = 1'b0;
    reset = 1'b0; #1;
    chk("mid_PCWrite", int'(pc_w), 0);
    chk("mid_IF_ID_Write", int'(ifid_w), 0);
    chk("mid_bubble", int'(bubble), 1);
    chk("mid_IF_ID_Flush", int'(ifid_f), 1);
    chk("mid_ID_EX_Flush", int'(idex_f), 1);
    chk("mid_flush_cycles", int'(flush_cnt), 0);
    step(); reset = 1'b1; #2;
    chk("post_PCWrite", int'(pc_w), 1);
    chk("post_IF_ID_Flush", int'(ifid_f), 0);
    chk("post_stall_cycles", int'(stall_cnt), 0);

    // Saturation of the stall counter
    reset_dut();
    ready = 1'b0;
    repeat (40) step();
    chk("sat_stall_cycles", int'(stall_cnt), SAT);
    ready = 1'b1;

    // Randomized traffic
    reset_dut();
    for (int i = 0; i < 4000; i++) begin
      step();
      br       = ($urandom % 8) == 0;
      ready    = ($urandom % 5) != 0;
      mem_read = ($urandom % 2) == 0;
      rd       = 5'($urandom % 4);
      rs1      = 5'($urandom % 4);
      rs2      = 5'($urandom % 4);
      reset    = ($urandom % 200) != 0;
    end
    step();
    reset = 1'b1;
    idle();
    step();
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/hazard_stall_controller.md
HAZARD_STALL_CONTROLLER -- requirements
Module: hazard_stall_controller

Interface
REQ-001 Parameter FLUSH_DEPTH, default 2, gives the fetch-redirect bubble count; legal range 1..15.
REQ-002 Parameter CNT_W, default 16, gives the width of the performance counters.
REQ-003 Port clk  input  1  is the single clock; all state updates on its rising edge.
REQ-004 Port reset  input  1  is an asynchronous, active-low reset.
REQ-005 Port ID_EX_MemRead  input  1  marks the instruction in EX as a load.
REQ-006 Port ID_EX_rd  input  5  is the destination register of the instruction in EX.
REQ-007 Port IF_ID_rs1, IF_ID_rs2  input  5 each  are the source registers of the instruction in ID.
REQ-008 Port branch_taken  input  1  is a taken branch or jump resolved in EX this cycle.
REQ-009 Port imem_ready  input  1  indicates instruction memory has valid data this cycle.
REQ-010 Port PCWrite  output  1  is the PC update enable; 0 holds the PC.
REQ-011 Port IF_ID_Write  output  1  is the IF/ID register write enable.
REQ-012 Port ctrl_bubble  output  1  zeroes ID/EX control signals (inserts a NOP).
REQ-013 Port IF_ID_Flush, ID_EX_Flush  output  1 each  clear the respective pipeline register.
REQ-014 Port stall_cycles, flush_cycles  output  CNT_W each  are saturating performance counters.

Function
REQ-015 The FSM states are RUN, LU_STALL and FLUSH, with a 4-bit down-counter flush_cnt.
REQ-016 A load-use hazard (lu_hit) exists when ID_EX_MemRead=1, ID_EX_rd!=0, and ID_EX_rd equals IF_ID_rs1 or IF_ID_rs2.
REQ-017 The control outputs are combinational from the current state and inputs, so they take effect in the same cycle as the triggering inputs.
REQ-018 Priority, highest first: branch_taken, then FLUSH state, then lu_hit, then !imem_ready.
REQ-019 branch_taken=1 in any state drives IF_ID_Flush=1, ID_EX_Flush=1 and PCWrite=1 that cycle; next state is FLUSH with flush_cnt=FLUSH_DEPTH-1.
REQ-020 In FLUSH with no new branch_taken, IF_ID_Flush=1 and PCWrite=imem_ready.
REQ-021 In FLUSH, flush_cnt decrements only when imem_ready=1; when flush_cnt=0 and imem_ready=1, next state is RUN.
REQ-022 In RUN, lu_hit=1 (no branch) drives PCWrite=0, IF_ID_Write=0 and ctrl_bubble=1; next state is LU_STALL.
REQ-023 LU_STALL lasts exactly one cycle; in it lu_hit is ignored (the bubble occupies EX) and the state returns to RUN.
REQ-024 In RUN or LU_STALL with imem_ready=0 and no higher-priority event, PCWrite=0 and IF_ID_Write=0, with ctrl_bubble=1 so that no stale instruction is issued.
REQ-025 When no condition is active, PCWrite=1 and IF_ID_Write=1, and every other control output is 0.
REQ-026 lu_hit together with branch_taken in the same cycle: the branch wins, no stall occurs, and stall_cycles does not increment.
REQ-027 stall_cycles increments in every cycle with PCWrite=0 outside FLUSH; it saturates at all-ones.
REQ-028 flush_cycles increments in every cycle with IF_ID_Flush=1; it saturates at all-ones.

Reset
REQ-029 Assertion of reset (low) immediately forces state=RUN, flush_cnt=0 and both counters=0, independent of clk.
REQ-030 While reset is low, PCWrite=0, IF_ID_Write=0, ctrl_bubble=1, IF_ID_Flush=1 and ID_EX_Flush=1.
REQ-031 On the first rising clk after reset deasserts, the block behaves per RUN; a reset arriving mid-FLUSH abandons the remaining flush count.

Structure
REQ-032 The state encoding (RUN=2'd0, LU_STALL=2'd1, FLUSH=2'd2) and the register-index width 5 belong in the shared pipeline package.
REQ-033 The saturating counter is one sub-module, sat_counter, instantiated twice.
REQ-034 The FSM and output decode reside in hazard_stall_controller; the estimated size is 150-250 lines of RTL.

Verification
REQ-035 Load-use: MemRead=1, rd=5, rs1=5, imem_ready=1 for one cycle -> PCWrite=0 and ctrl_bubble=1 that cycle, PCWrite=1 next cycle, stall_cycles=1.
REQ-036 rd=0: MemRead=1, rd=0, rs2=0 -> no stall; PCWrite=1 and stall_cycles=0.
REQ-037 Branch, FLUSH_DEPTH=2: branch_taken pulse, imem_ready=1 -> IF_ID_Flush=1 for 3 consecutive cycles, ID_EX_Flush=1 for 1 cycle, flush_cycles=3.
REQ-038 Simultaneous events: branch_taken=1 with lu_hit=1 -> PCWrite=1, flushes asserted, ctrl_bubble=0, stall_cycles unchanged.
REQ-039 imem wait in FLUSH: imem_ready=0 for 2 cycles mid-flush -> flush extends by 2 cycles and PCWrite=0 during the wait.
REQ-040 Reset mid-FLUSH: reset low for 1 cycle -> all outputs take the REQ-030 values asynchronously; after release the state is RUN and the counters are 0.
